// File: rtl/wide_add_pkg.sv
// Shared constants and types for the multi-precision add/sub sequencer.
// The limb width is fixed by the single 16-bit slice adder.
package wide_add_pkg;

    localparam int unsigned LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_2byte_wide.sv
// 16-bit ripple carry-chain adder slice: {co, s} = a + b + ci.
module full_adder_2byte_wide
    import wide_add_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              ci,
    output logic [LIMB_W-1:0] s,
    output logic              co
);

    logic [LIMB_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < LIMB_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[LIMB_W];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision adder/subtractor: one 16-bit slice is stepped over NUM_WORDS limbs,
// least significant first, with the carry registered between steps.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sub,
    input  logic [NUM_WORDS*LIMB_W-1:0] in_a,
    input  logic [NUM_WORDS*LIMB_W-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_WORDS*LIMB_W-1:0] out_sum,
    output logic                        out_carry,
    output logic                        busy
);

    localparam int unsigned W     = NUM_WORDS * LIMB_W;
    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_sr_q, a_sr_d;
    logic [W-1:0]     b_sr_q, b_sr_d;
    logic [W-1:0]     sum_sr_q, sum_sr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             carry_out_q, carry_out_d;
    logic             in_ready_q, in_ready_d;

    logic [LIMB_W-1:0] slice_s;
    logic              slice_co;
    logic              accept;

    full_adder_2byte_wide u_slice (
        .a  (a_sr_q[LIMB_W-1:0]),
        .b  (b_sr_q[LIMB_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = RUN;
                    a_sr_d   = in_a;
                    // Subtraction as A + ~B + 1: the +1 enters through the initial carry.
                    b_sr_d   = in_sub ? ~in_b : in_b;
                    carry_d  = in_sub;
                    sum_sr_d = '0;
                    idx_d    = '0;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> LIMB_W;
                b_sr_d   = b_sr_q >> LIMB_W;
                sum_sr_d = (sum_sr_q >> LIMB_W) | (W'(slice_s) << (W - LIMB_W));
                carry_d  = slice_co;
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    carry_out_d = slice_co;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    // Partial sums never leave the block.
    assign out_sum   = out_valid ? sum_sr_q : '0;
    assign out_carry = carry_out_q;

    a_ready_idle: assert property (@(posedge clk) disable iff (reset)
        in_ready |-> (state_q == IDLE));

    a_result_hold: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_carry)));

endmodule
